// File: rtl/convert_hsv_to_rgb_pkg.sv
// Shared types, field positions and address helpers for the HSV->RGB stage.
package convert_hsv_to_rgb_pkg;

    localparam int unsigned AddrWidth = 18;
    localparam int unsigned DataWidth = 32;

    localparam int unsigned HsvHueLsb = 24;
    localparam int unsigned HsvSatLsb = 8;
    localparam int unsigned HsvValLsb = 0;

    localparam int unsigned RgbRedLsb   = 0;
    localparam int unsigned RgbGreenLsb = 8;
    localparam int unsigned RgbBlueLsb  = 24;

    // Hue codes at or above this carry no colour; the producer writes 192 for black.
    localparam logic [7:0] HueLimit = 8'd192;

    typedef enum logic [1:0] {
        S_ADDR,
        S_READ,
        S_CALC,
        S_WRITE
    } state_e;

    function automatic int unsigned hsv_base(input int unsigned w, input int unsigned h);
        return w * h * 2 + 2;
    endfunction

    function automatic int unsigned rgb_base(input int unsigned w, input int unsigned h);
        return w * h + 1;
    endfunction

    function automatic logic [DataWidth-1:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                                      input logic [7:0] b);
        logic [DataWidth-1:0] word;
        word                      = '0;
        word[RgbRedLsb +: 8]      = r;
        word[RgbGreenLsb +: 8]    = g;
        word[RgbBlueLsb +: 8]     = b;
        return word;
    endfunction

endpackage

// File: rtl/convert_hsv_to_rgb_hsv_sector_mix.sv
// Registered HSV sector mixer: computes p/q/t from (f, s, v) and picks (r,g,b) by sector.
module convert_hsv_to_rgb_hsv_sector_mix (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [2:0] i_sector,
    input  logic [7:0] i_f,
    input  logic [7:0] i_s,
    input  logic [7:0] i_v,
    input  logic       i_nohue,
    output logic [7:0] o_r,
    output logic [7:0] o_g,
    output logic [7:0] o_b
);

    logic [8:0]  w_s_inv;
    logic [8:0]  w_f_inv;
    logic [16:0] w_sf;
    logic [16:0] w_sf_inv;
    logic [16:0] w_q_fac;
    logic [16:0] w_t_fac;
    logic [24:0] w_p_prod;
    logic [24:0] w_q_prod;
    logic [24:0] w_t_prod;
    logic [7:0]  w_p;
    logic [7:0]  w_q;
    logic [7:0]  w_t;
    logic [7:0]  w_r_sel;
    logic [7:0]  w_g_sel;
    logic [7:0]  w_b_sel;
    logic [7:0]  r_r;
    logic [7:0]  r_g;
    logic [7:0]  r_b;

    assign w_s_inv  = 9'd256 - {1'b0, i_s};
    assign w_f_inv  = 9'd256 - {1'b0, i_f};
    assign w_sf     = {9'd0, i_s} * {9'd0, i_f};
    assign w_sf_inv = {9'd0, i_s} * {8'd0, w_f_inv};
    // f <= 248, so both factors stay positive and below 2^17.
    assign w_q_fac  = 17'h10000 - w_sf;
    assign w_t_fac  = 17'h10000 - w_sf_inv;

    assign w_p_prod = {17'd0, i_v} * {16'd0, w_s_inv};
    assign w_q_prod = {17'd0, i_v} * {8'd0, w_q_fac};
    assign w_t_prod = {17'd0, i_v} * {8'd0, w_t_fac};

    assign w_p = 8'(w_p_prod >> 8);
    assign w_q = 8'(w_q_prod >> 16);
    assign w_t = 8'(w_t_prod >> 16);

    always_comb begin
        w_r_sel = i_v;
        w_g_sel = i_v;
        w_b_sel = i_v;
        if (!i_nohue) begin
            case (i_sector)
                3'd0: begin w_r_sel = i_v; w_g_sel = w_t; w_b_sel = w_p; end
                3'd1: begin w_r_sel = w_q; w_g_sel = i_v; w_b_sel = w_p; end
                3'd2: begin w_r_sel = w_p; w_g_sel = i_v; w_b_sel = w_t; end
                3'd3: begin w_r_sel = w_p; w_g_sel = w_q; w_b_sel = i_v; end
                3'd4: begin w_r_sel = w_t; w_g_sel = w_p; w_b_sel = i_v; end
                3'd5: begin w_r_sel = i_v; w_g_sel = w_p; w_b_sel = w_q; end
                default: begin w_r_sel = i_v; w_g_sel = i_v; w_b_sel = i_v; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end else if (i_en) begin
            r_r <= w_r_sel;
            r_g <= w_g_sel;
            r_b <= w_b_sel;
        end
    end

    assign o_r = r_r;
    assign o_g = r_g;
    assign o_b = r_b;

endmodule

// File: rtl/convert_hsv_to_rgb.sv
// HSV->RGB frame stage: walks the packed HSV region in shared SRAM and writes one RGB word
// per pixel, four clocks per pixel, with enable/pause/done sequencing.
module convert_hsv_to_rgb
    import convert_hsv_to_rgb_pkg::*;
#(
    parameter int unsigned ImageWidth       = 320,
    parameter int unsigned ImageHeight      = 240,
    parameter int unsigned HSVStorageOffset = hsv_base(ImageWidth, ImageHeight),
    parameter int unsigned RGBOutputOffset  = rgb_base(ImageWidth, ImageHeight)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 pause,
    input  logic [DataWidth-1:0] data_read,
    output logic                 wren,
    output logic [AddrWidth-1:0] address,
    output logic [DataWidth-1:0] data_write,
    output logic                 done
);

    localparam logic [AddrWidth-1:0] HsvBase    = AddrWidth'(HSVStorageOffset);
    localparam logic [AddrWidth-1:0] RgbBase    = AddrWidth'(RGBOutputOffset);
    localparam logic [AddrWidth-1:0] PixelCount = AddrWidth'(ImageWidth * ImageHeight);

    state_e               r_state,      w_state_nxt;
    logic [AddrWidth-1:0] r_counter,    w_counter_nxt;
    logic                 r_wren,       w_wren_nxt;
    logic [AddrWidth-1:0] r_address,    w_address_nxt;
    logic [DataWidth-1:0] r_data_write, w_data_write_nxt;
    logic                 r_done,       w_done_nxt;
    logic [7:0]           r_h,          w_h_nxt;
    logic [7:0]           r_s,          w_s_nxt;
    logic [7:0]           r_v,          w_v_nxt;

    logic [AddrWidth-1:0] w_cnt_inc;
    logic [2:0]           w_sector;
    logic [7:0]           w_f;
    logic                 w_nohue;
    logic                 w_mix_en;
    logic [7:0]           w_r;
    logic [7:0]           w_g;
    logic [7:0]           w_b;

    assign w_cnt_inc = r_counter + 1'b1;
    assign w_sector  = r_h[7:5];
    assign w_f       = {r_h[4:0], 3'b000};
    assign w_nohue   = (r_h >= HueLimit) || (r_s == 8'd0);
    assign w_mix_en  = enable && !pause && (r_state == S_CALC);

    convert_hsv_to_rgb_hsv_sector_mix u_mix (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_mix_en),
        .i_sector (w_sector),
        .i_f      (w_f),
        .i_s      (r_s),
        .i_v      (r_v),
        .i_nohue  (w_nohue),
        .o_r      (w_r),
        .o_g      (w_g),
        .o_b      (w_b)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_counter_nxt    = r_counter;
        w_wren_nxt       = r_wren;
        w_address_nxt    = r_address;
        w_data_write_nxt = r_data_write;
        w_done_nxt       = r_done;
        w_h_nxt          = r_h;
        w_s_nxt          = r_s;
        w_v_nxt          = r_v;

        if (!enable) begin
            w_state_nxt      = S_ADDR;
            w_counter_nxt    = '0;
            w_wren_nxt       = 1'b0;
            w_address_nxt    = '0;
            w_data_write_nxt = '0;
            w_done_nxt       = 1'b0;
        end else if (!pause) begin
            if (r_done) begin
                // Frame finished: idle with the port quiet until enable drops.
                w_wren_nxt = 1'b0;
            end else begin
                unique case (r_state)
                    S_ADDR: begin
                        w_address_nxt = HsvBase + r_counter;
                        w_wren_nxt    = 1'b0;
                        w_state_nxt   = S_READ;
                    end
                    S_READ: begin
                        w_h_nxt     = data_read[HsvHueLsb +: 8];
                        w_s_nxt     = data_read[HsvSatLsb +: 8];
                        w_v_nxt     = data_read[HsvValLsb +: 8];
                        w_state_nxt = S_CALC;
                    end
                    S_CALC: begin
                        w_state_nxt = S_WRITE;
                    end
                    S_WRITE: begin
                        w_address_nxt    = RgbBase + r_counter;
                        w_data_write_nxt = pack_rgb(w_r, w_g, w_b);
                        w_wren_nxt       = 1'b1;
                        w_counter_nxt    = w_cnt_inc;
                        w_done_nxt       = (w_cnt_inc >= PixelCount);
                        w_state_nxt      = S_ADDR;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_ADDR;
            r_counter    <= '0;
            r_wren       <= 1'b0;
            r_address    <= '0;
            r_data_write <= '0;
            r_done       <= 1'b0;
            r_h          <= '0;
            r_s          <= '0;
            r_v          <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_counter    <= w_counter_nxt;
            r_wren       <= w_wren_nxt;
            r_address    <= w_address_nxt;
            r_data_write <= w_data_write_nxt;
            r_done       <= w_done_nxt;
            r_h          <= w_h_nxt;
            r_s          <= w_s_nxt;
            r_v          <= w_v_nxt;
        end
    end

    assign wren       = r_wren;
    assign address    = r_address;
    assign data_write = r_data_write;
    assign done       = r_done;

endmodule

// File: tb/tb_convert_hsv_to_rgb.sv
// Self-checking bench for convert_hsv_to_rgb on a 4x2 frame against an arithmetic HSV model.
module tb_convert_hsv_to_rgb;

    localparam int unsigned W   = 4;
    localparam int unsigned H   = 2;
    localparam int unsigned N   = W * H;
    localparam int unsigned HSV = N * 2 + 2;
    localparam int unsigned RGB = N + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        pause;
    logic [31:0] data_read;
    logic        wren;
    logic [17:0] address;
    logic [31:0] data_write;
    logic        done;

    logic [31:0] mem [0:63];
    logic [31:0] got [0:7];
    int          got_cnt;
    bit          order_ok;
    int          n_pass   = 0;
    int          n_checks = 0;

    always #5 clk = ~clk;

    // Asynchronous-read SRAM: data follows the registered address.
    assign data_read = mem[address[5:0]];

    convert_hsv_to_rgb #(
        .ImageWidth  (W),
        .ImageHeight (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pause      (pause),
        .data_read  (data_read),
        .wren       (wren),
        .address    (address),
        .data_write (data_write),
        .done       (done)
    );

    function automatic logic [31:0] model_rgb(input logic [31:0] hsv);
        int h, s, v, f, p, q, t, r, g, b;
        h = int'(hsv[31:24]);
        s = int'(hsv[15:8]);
        v = int'(hsv[7:0]);
        if (h >= 192 || s == 0) begin
            r = v; g = v; b = v;
        end else begin
            f = (h % 32) * 8;
            p = (v * (256 - s)) / 256;
            q = (v * (65536 - s * f)) / 65536;
            t = (v * (65536 - s * (256 - f))) / 65536;
            case (h / 32)
                0: begin r = v; g = t; b = p; end
                1: begin r = q; g = v; b = p; end
                2: begin r = p; g = v; b = t; end
                3: begin r = p; g = q; b = v; end
                4: begin r = t; g = p; b = v; end
                default: begin r = v; g = p; b = q; end
            endcase
        end
        return {8'(b), 8'h00, 8'(g), 8'(r)};
    endfunction

    task automatic idle_enable_low();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_frame();
        got_cnt  = 0;
        order_ok = 1'b1;
        for (int i = 0; i < 8; i++) got[i] = 'x;
        enable = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk);
            #1;
            if (wren && !pause) begin
                if (int'(address) != int'(RGB) + got_cnt) order_ok = 1'b0;
                if (got_cnt < 8) got[got_cnt] = data_write;
                got_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        pause  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (wren !== 1'b0) $display("FAIL reset_wren got %b want 0", wren); else n_pass++;
        n_checks++; if (address !== 18'd0) $display("FAIL reset_addr got %0d want 0", address); else n_pass++;
        n_checks++; if (data_write !== 32'd0) $display("FAIL reset_data got %h want 0", data_write); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pure_red();
        int first;
        logic [17:0] a;
        logic [31:0] d;
        first = -1;
        a = '0;
        d = '0;
        mem[HSV] = 32'h0000FFFF;
        @(negedge clk);
        enable = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (wren && first < 0) begin
                first = c;
                a = address;
                d = data_write;
            end
        end
        n_checks++; if (first != 4) $display("FAIL red_latency got %0d want 4", first); else n_pass++;
        n_checks++; if (int'(a) != int'(RGB)) $display("FAIL red_addr got %0d want %0d", a, RGB); else n_pass++;
        n_checks++; if (d !== 32'h000000FF) $display("FAIL red_data got %h want 000000ff", d); else n_pass++;
        idle_enable_low();
    endtask

    task automatic test_directed_frame();
        logic [31:0] pix [0:7];
        logic [31:0] lit [0:5];
        pix[0] = 32'h0000FFFF; lit[0] = 32'h000000FF;
        pix[1] = 32'h4000FFFF; lit[1] = 32'h0000FF00;
        pix[2] = 32'h8000FFFF; lit[2] = 32'hFF000000;
        pix[3] = 32'h1000FFFF; lit[3] = 32'h00007FFF;
        pix[4] = 32'hC0000064; lit[4] = 32'h64006464;
        pix[5] = 32'hFF00C864; lit[5] = 32'h64006464;
        pix[6] = 32'h640080C8;
        pix[7] = 32'hBF00FFFF;
        for (int i = 0; i < 8; i++) mem[HSV + i] = pix[i];
        run_frame();
        n_checks++; if (done !== 1'b1) $display("FAIL frame_done got %b want 1", done); else n_pass++;
        n_checks++; if (got_cnt != 8) $display("FAIL frame_writes got %0d want 8", got_cnt); else n_pass++;
        n_checks++; if (!order_ok) $display("FAIL frame_order got out-of-order want sequential"); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got[i] !== lit[i]) $display("FAIL dir_lit[%0d] got %h want %h", i, got[i], lit[i]);
            else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (got[i] !== model_rgb(pix[i]))
                $display("FAIL dir_model[%0d] got %h want %h", i, got[i], model_rgb(pix[i]));
            else n_pass++;
        end
    endtask

    task automatic test_done_hold();
        int extra;
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (wren) extra++;
        end
        n_checks++; if (extra != 0) $display("FAIL done_no_wren got %0d want 0", extra); else n_pass++;
        n_checks++; if (done !== 1'b1) $display("FAIL done_held got %b want 1", done); else n_pass++;
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) $display("FAIL done_clear got %b want 0", done); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random_frames();
        logic [31:0] pix [0:7];
        logic [7:0]  h, s, v;
        for (int fr = 0; fr < 3; fr++) begin
            for (int i = 0; i < 8; i++) begin
                h = 8'($urandom_range(0, 255));
                s = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                v = 8'($urandom);
                pix[i] = {h, 8'h00, s, v};
                mem[HSV + i] = pix[i];
            end
            run_frame();
            n_checks++;
            if (got_cnt != 8 || !order_ok)
                $display("FAIL rand_frame%0d_writes got %0d ordered=%0b want 8 ordered=1", fr,
                         got_cnt, order_ok);
            else n_pass++;
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (got[i] !== model_rgb(pix[i]))
                    $display("FAIL rand%0d[%0d] hsv %h got %h want %h", fr, i, pix[i], got[i],
                             model_rgb(pix[i]));
                else n_pass++;
            end
            idle_enable_low();
        end
    endtask

    task automatic test_pause();
        int first;
        logic [31:0] d;
        first = -1;
        d = '0;
        mem[HSV] = 32'h0000FFFF;
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pause = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        mem[HSV] = 32'h8000FFFF;
        @(posedge clk);
        @(negedge clk);
        pause = 1'b0;
        for (int c = 5; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (wren && first < 0) begin
                first = c;
                d = data_write;
            end
        end
        n_checks++; if (first != 7) $display("FAIL pause_latency got %0d want 7", first); else n_pass++;
        n_checks++;
        if (d !== model_rgb(32'h8000FFFF))
            $display("FAIL pause_data got %h want %h", d, model_rgb(32'h8000FFFF));
        else n_pass++;
        idle_enable_low();
    endtask

    task automatic test_async_reset();
        int seen, first;
        logic [17:0] a;
        logic [31:0] d;
        seen = 0;
        first = -1;
        a = '0;
        d = '0;
        for (int i = 0; i < 8; i++) mem[HSV + i] = {8'($urandom_range(0, 191)), 8'h00, 8'($urandom),
                                                   8'($urandom)};
        @(negedge clk);
        enable = 1'b1;
        for (int c = 0; c < 40 && seen < 3; c++) begin
            @(posedge clk);
            #1;
            if (wren) seen++;
        end
        n_checks++; if (seen != 3) $display("FAIL arst_setup got %0d writes want 3", seen); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (wren !== 1'b0) $display("FAIL arst_wren got %b want 0", wren); else n_pass++;
        n_checks++; if (address !== 18'd0) $display("FAIL arst_addr got %0d want 0", address); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (wren && first < 0) begin
                first = c;
                a = address;
                d = data_write;
            end
        end
        n_checks++;
        if (first != 4 || int'(a) != int'(RGB))
            $display("FAIL arst_restart got cycle %0d addr %0d want cycle 4 addr %0d", first, a, RGB);
        else n_pass++;
        n_checks++;
        if (d !== model_rgb(mem[HSV]))
            $display("FAIL arst_data got %h want %h", d, model_rgb(mem[HSV]));
        else n_pass++;
        idle_enable_low();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_pure_red();
        test_directed_frame();
        test_done_hold();
        test_random_frames();
        test_pause();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
